// File: rtl/ci_sequencer.sv
// ci_sequencer: hardware initiator for the PE group's variable-multicycle
// custom-instruction interface. It takes one command at a time from a
// valid/ready port, runs it as a single start/done transfer (with a timeout
// abort), and returns one response per command on a valid/ready port.
module ci_sequencer #(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024,
  parameter int TimerWidth    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_n,
  input  logic [DataWidth-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 ci_clk_en,
  output logic                 ci_start,
  output logic [2:0]           ci_n,
  output logic [DataWidth-1:0] ci_dataa,
  input  logic                 ci_done,
  input  logic [DataWidth-1:0] ci_result,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // The PE group acts on n=0 (clear) and n=4 (pop) even without start,
  // so the interface parks on this opcode whenever no transfer is active.
  localparam logic [2:0]            NIdle     = 3'd7;
  localparam logic [2:0]            NLastOp   = 3'd4;
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  state_t                 state_q;
  logic                   ci_clk_en_q;
  logic                   ci_start_q;
  logic [2:0]             ci_n_q;
  logic [DataWidth-1:0]   ci_dataa_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [DataWidth-1:0]   rsp_data_q;
  logic [TimerWidth-1:0]  timer_q;

  logic cmd_ready_d;
  logic cmd_accept;
  logic cmd_legal;

  // Ready in IDLE once out of reset; in RESP a new command may ride in on
  // the same cycle the pending response is consumed.
  always_comb begin
    cmd_ready_d = ci_clk_en_q &&
                  ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    cmd_accept  = cmd_valid && cmd_ready_d;
    cmd_legal   = (cmd_n <= NLastOp);
  end

  // Sequencer FSM; every interface output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ci_clk_en_q <= 1'b0;
      ci_start_q  <= 1'b0;
      ci_n_q      <= NIdle;
      ci_dataa_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      timer_q     <= '0;
    end else begin
      ci_clk_en_q <= 1'b1;
      case (state_q)
        IDLE, RESP: begin
          if (cmd_accept) begin
            if (cmd_legal) begin
              ci_start_q  <= 1'b1;
              ci_n_q      <= cmd_n;
              ci_dataa_q  <= cmd_data;
              timer_q     <= '0;
              rsp_valid_q <= 1'b0;
              state_q     <= ISSUE;
            end else begin
              // Illegal opcode never reaches the PE group.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= RESP;
            end
          end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ISSUE: begin
          // Done takes priority, so a completion in the last allowed cycle
          // still produces a normal response.
          if (ci_done) begin
            rsp_data_q  <= ci_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            ci_start_q  <= 1'b0;
            ci_n_q      <= NIdle;
            state_q     <= RESP;
          end else if (timer_q == TimerLast) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            ci_start_q  <= 1'b0;
            ci_n_q      <= NIdle;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          ci_start_q <= 1'b0;
          ci_n_q     <= NIdle;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ci_clk_en = ci_clk_en_q;
  assign ci_start  = ci_start_q;
  assign ci_n      = ci_n_q;
  assign ci_dataa  = ci_dataa_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ci_sequencer.sv
// tb_ci_sequencer: directed and randomized commands against a transaction
// level model of the sequencer, with a PE-group model that answers after a
// programmable number of cycles (or never).
module tb_ci_sequencer;

  localparam int DW = 32;
  localparam int T  = 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_n;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          ci_clk_en;
  logic          ci_start;
  logic [2:0]    ci_n;
  logic [DW-1:0] ci_dataa;
  logic          ci_done;
  logic [DW-1:0] ci_result;
  logic          busy;

  int            n_assert = 0;
  int            n_fail   = 0;

  // PE-group model: done after pe_delay extra cycles of ci_start.
  int            pe_cnt = 0;
  int            pe_delay = 0;
  logic [DW-1:0] pe_result = '0;

  ci_sequencer #(.DataWidth(DW), .TimeoutCycles(T), .TimerWidth(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n), .ci_dataa(ci_dataa),
    .ci_done(ci_done), .ci_result(ci_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ci_start) pe_cnt <= pe_cnt + 1;
    else          pe_cnt <= 0;
  end

  assign ci_done   = ci_start && (pe_cnt == pe_delay);
  assign ci_result = ci_done ? pe_result : 32'h0BAD_0BAD;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end; the response is left pending for 'hold' cycles
  // and is consumed by the next command's accept or by drain().
  task automatic run_cmd(input logic [2:0] n, input logic [DW-1:0] d,
                         input int delay, input logic [DW-1:0] res, input int hold);
    bit            legal;
    int            exp_starts, exp_lat, starts, lat, first_start;
    bit            exp_err, bad_hold, bad_idle;
    logic [DW-1:0] exp_data;
    legal      = (n <= 3'd4);
    exp_starts = legal ? ((delay + 1 < T) ? delay + 1 : T) : 0;
    exp_lat    = legal ? exp_starts + 1 : 1;
    exp_err    = !legal || (delay >= T);
    exp_data   = exp_err ? '0 : res;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = n; cmd_data = d;
    pe_delay  = delay; pe_result = res;
    rsp_ready = 1'b1;
    #1;
    chk("cmd_ready_at_offer", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;

    starts = 0; lat = 0; first_start = 0; bad_hold = 0; bad_idle = 0;
    for (int k = 1; k <= T + 4; k++) begin
      @(negedge clk);
      if (ci_start) begin
        starts++;
        if (first_start == 0) first_start = k;
        if (ci_n !== n || ci_dataa !== d) bad_hold = 1;
      end else if (ci_n !== 3'd7) begin
        bad_idle = 1;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("rsp_latency", lat, exp_lat);
    chk("start_cycles", starts, exp_starts);
    chk("first_start", first_start, legal ? 1 : 0);
    chk("ci_n_dataa_stable", bad_hold, 1'b0);
    chk("ci_n_idle_7", bad_idle, 1'b0);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("backpressure_hold", {rsp_valid, rsp_err, rsp_data, cmd_ready, ci_start},
          {1'b1, exp_err, exp_data, 1'b0, 1'b0});
    end
    $display("txn n=%0d data=%08h delay=%0d -> rsp_data=%08h err=%0b lat=%0d starts=%0d",
             n, d, delay, rsp_data, rsp_err, lat, starts);
  endtask

  task automatic drain();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("drain_rsp_valid", rsp_valid, 1'b0);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    logic [2:0]    rn;
    logic [DW-1:0] rd, rr;
    int            rdel, rhold;

    // Reset with a command already offered.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_n = 3'd1; cmd_data = 32'hA5A5_A5A5; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ci_start", ci_start, 1'b0);
    chk("reset_ci_n", ci_n, 3'd7);
    chk("reset_ci_clk_en", ci_clk_en, 1'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
    chk("reset_busy_dataa", {busy, ci_dataa}, '0);
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("first_clk_clk_en", ci_clk_en, 1'b1);
    chk("first_clk_cmd_ready", cmd_ready, 1'b1);
    chk("first_clk_no_start", ci_start, 1'b0);
    cmd_valid = 1'b0;

    // Directed cases.
    run_cmd(3'd1, 32'h1234_5678, 0, 32'h1234_5678, 0);   // immediate weight load
    run_cmd(3'd4, 32'h0000_0000, 5, 32'hDEAD_BEEF, 0);   // slow read
    run_cmd(3'd2, 32'h5555_AAAA, 100, 32'h1111_1111, 0); // timeout
    run_cmd(3'd3, 32'h0F0F_0F0F, T - 1, 32'hCAFE_F00D, 0); // done in last cycle
    run_cmd(3'd0, 32'h0000_0001, 0, 32'h0000_0000, 4);   // clear, backpressure
    run_cmd(3'd1, 32'h8765_4321, 0, 32'h0246_8ACE, 0);   // back-to-back accept
    run_cmd(3'd6, 32'hFFFF_FFFF, 0, 32'h1357_9BDF, 1);   // illegal opcode
    run_cmd(3'd7, 32'h0000_0007, 0, 32'h0000_0000, 0);   // illegal, idle opcode
    drain();

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      rn    = 3'($urandom_range(0, 7));
      rd    = $urandom;
      rr    = $urandom;
      rdel  = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
      rhold = $urandom_range(0, 3);
      run_cmd(rn, rd, rdel, rr, rhold);
    end
    drain();

    // Reset in the middle of a transfer.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 3'd2; cmd_data = 32'h7777_0000;
    pe_delay = 100; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_issue_start", ci_start, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_start", ci_start, 1'b0);
    chk("async_reset_state", {ci_n, busy, rsp_valid, cmd_ready}, {3'd7, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {rsp_valid, ci_start}, 2'b00);
    end
    run_cmd(3'd1, 32'h0BEE_F123, 1, 32'h0BEE_F123, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
